// File: rtl/mac_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Brief    : Shared constants and state encoding for the MAC sequencer.
// Revision : 1.0
// ============================================================================
package mac_pkg;

    localparam int MAC_DATA_W = 8;
    localparam int MAC_IDX_W  = 4;
    localparam int MAC_DEPTH  = 16;
    localparam int MAC_ACC_W  = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } mac_state_e;

endpackage
`default_nettype wire

// File: rtl/mac_mul_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_mul_stage
// Brief    : Registered signed multiplier with a valid flag.
// Revision : 1.0
// ============================================================================
module mac_mul_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    input  logic                       in_v,
    output logic signed [2*DATA_W-1:0] prod,
    output logic                       prod_v
);

    logic signed [2*DATA_W-1:0] prod_q;
    logic                       prod_v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
        end else begin
            prod_v_q <= in_v;
            if (in_v) begin
                prod_q <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
            end
        end
    end

    assign prod   = prod_q;
    assign prod_v = prod_v_q;

endmodule
`default_nettype wire

// File: rtl/mac_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_seq
// Brief    : Walks two byte buffers, accumulates signed products, and
//            returns the dot product over a ready/valid port.
// Revision : 1.0
// ============================================================================
module mac_seq
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int IDX_W  = MAC_IDX_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int RELU   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [IDX_W:0]           len,
    input  logic signed [DATA_W-1:0] filt_data,
    input  logic signed [DATA_W-1:0] in_data,
    output logic [IDX_W-1:0]         idx,
    output logic                     buf_lock,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data
);

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(1 << IDX_W);
    localparam logic [IDX_W:0] ONE_L   = (IDX_W+1)'(1);

    mac_state_e               state_q;
    logic [IDX_W:0]           n_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  out_data_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     buf_lock_q;

    logic signed [2*DATA_W-1:0] prod;
    logic                       prod_v;
    logic signed [ACC_W-1:0]    acc_d;
    logic [IDX_W:0]             n_d;
    logic                       last_d;

    mac_mul_stage #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (filt_data),
        .b      (in_data),
        .in_v   (state_q == RUN),
        .prod   (prod),
        .prod_v (prod_v)
    );

    // The product pipeline lags the index by one cycle; DRAIN folds in the tail.
    assign acc_d  = acc_q + ACC_W'(prod);
    assign n_d    = (len > DEPTH_L) ? DEPTH_L : len;
    assign last_d = ({1'b0, idx_q} == (n_q - ONE_L));

    function automatic logic signed [ACC_W-1:0] relu_f(input logic signed [ACC_W-1:0] v);
        return ((RELU != 0) && v[ACC_W-1]) ? '0 : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            buf_lock_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= '0;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            out_data_q  <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= OUT;
                        end else begin
                            n_q        <= n_d;
                            buf_lock_q <= 1'b1;
                            state_q    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (prod_v) begin
                        acc_q <= acc_d;
                    end
                    if (last_d) begin
                        buf_lock_q <= 1'b0;
                        state_q    <= DRAIN;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    acc_q       <= acc_d;
                    out_data_q  <= relu_f(acc_d);
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign idx       = idx_q;
    assign buf_lock  = buf_lock_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_seq
// Brief    : Directed and random checks of mac_seq with and without ReLU.
// Revision : 1.0
// ============================================================================
module tb_mac_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] len = '0;

    logic signed [7:0] fmem [16];
    logic signed [7:0] xmem [16];

    logic [3:0]        idx0, idx1;
    logic signed [7:0] f0, x0, f1, x1;
    logic              lock0, lock1, busy0, busy1, ov0, ov1;
    logic [19:0]       od0, od1;

    assign f0 = fmem[idx0];
    assign x0 = xmem[idx0];
    assign f1 = fmem[idx1];
    assign x1 = xmem[idx1];

    mac_seq #(.DATA_W(8), .IDX_W(4), .ACC_W(20), .RELU(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .filt_data(f0), .in_data(x0), .idx(idx0), .buf_lock(lock0),
        .busy(busy0), .out_valid(ov0), .out_ready(out_ready), .out_data(od0)
    );

    mac_seq #(.DATA_W(8), .IDX_W(4), .ACC_W(20), .RELU(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .filt_data(f1), .in_data(x1), .idx(idx1), .buf_lock(lock1),
        .busy(busy1), .out_valid(ov1), .out_ready(out_ready), .out_data(od1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_sum(input int terms);
        int s = 0;
        for (int k = 0; k < terms; k++) s += int'(fmem[k]) * int'(xmem[k]);
        return s;
    endfunction

    task automatic fill(input int fv, input int xv, input bit ramp);
        for (int k = 0; k < 16; k++) begin
            fmem[k] = ramp ? 8'(k + 1) : 8'(fv);
            xmem[k] = 8'(xv);
        end
    endtask

    task automatic run_job(input int l, input bit early, input int hold);
        int n = (l > 16) ? 16 : l;
        int s = ref_sum(n);
        int lat = (n == 0) ? 1 : n + 2;
        int cyc;
        logic [19:0] e0 = 20'(s);
        logic [19:0] e1 = 20'((s < 0) ? 0 : s);
        @(negedge clk);
        start = 1'b1; len = 5'(l); out_ready = early;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (ov0 !== 1'b1 && cyc <= 24) begin
            chk("busy_run", {31'b0, busy0}, 1);
            chk("lock_run", {31'b0, lock0}, (cyc <= n) ? 1 : 0);
            if (cyc <= n) chk("idx_seq", {28'b0, idx0}, cyc - 1);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("ov_relu", {31'b0, ov1}, 1);
        chk("data", {12'b0, od0}, {12'b0, e0});
        chk("data_relu", {12'b0, od1}, {12'b0, e1});
        chk("lock_out", {31'b0, lock0}, 0);
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                start = 1'b1;
                @(posedge clk); #1;
                chk("hold_valid", {31'b0, ov0}, 1);
                chk("hold_data", {12'b0, od0}, {12'b0, e0});
                chk("hold_busy", {31'b0, busy0}, 1);
            end
            start = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("busy_idle", {31'b0, busy0}, 0);
        chk("ov_idle", {31'b0, ov0}, 0);
        chk("data_keep", {12'b0, od0}, {12'b0, e0});
        chk("data_keep_relu", {12'b0, od1}, {12'b0, e1});
    endtask

    initial begin
        fill(0, 0, 1'b0);
        #2;
        chk("rst_idx", {28'b0, idx0}, 0);
        chk("rst_lock", {31'b0, lock0}, 0);
        chk("rst_busy", {31'b0, busy0}, 0);
        chk("rst_valid", {31'b0, ov0}, 0);
        chk("rst_data", {12'b0, od0}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fill(1, 1, 1'b0);       run_job(16, 1'b0, 0);
        fill(-128, -128, 1'b0); run_job(16, 1'b1, 0);
        fill(127, -128, 1'b0);  run_job(16, 1'b0, 0);
        fill(0, 10, 1'b1);      run_job(3, 1'b0, 0);
        run_job(0, 1'b0, 0);
        run_job(20, 1'b1, 0);
        run_job(16, 1'b0, 0);
        run_job(5, 1'b0, 5);
        run_job(2, 1'b1, 0);

        // Reset mid-run must discard the partial sum.
        fill(-7, 9, 1'b0);
        @(negedge clk);
        start = 1'b1; len = 5'd16;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && idx0 !== 4'd7; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_idx", {28'b0, idx0}, 7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_idx", {28'b0, idx0}, 0);
        chk("mid_rst_lock", {31'b0, lock0}, 0);
        chk("mid_rst_busy", {31'b0, busy0}, 0);
        chk("mid_rst_valid", {31'b0, ov0}, 0);
        chk("mid_rst_data", {12'b0, od0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill(0, 3, 1'b1);
        run_job(4, 1'b0, 1);

        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 16; k++) begin
                fmem[k] = 8'($urandom);
                xmem[k] = 8'($urandom);
            end
            run_job(int'($urandom_range(0, 20)), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_seq.md
# mac_seq

Sequencer and multiply-accumulate datapath directly downstream of the two 16-entry byte buffers (`mac_buf`, one holding filter weights, one holding input activations). On `start` it walks the shared read index over the first `len` entries and reads one byte pair per cycle from the buffers' combinational outputs. It accumulates the signed products and presents the sum on a ready/valid output port. It also tells the upstream loader when the buffers are locked.

## Interface
- `DATA_W`, 8: width of each buffer entry, signed two's complement
- `IDX_W`, 4: buffer index width (16 entries)
- `ACC_W`, 20: accumulator and result width, signed; 16 × (−128 × −128) fits without overflow
- `RELU`, 0: 1 clamps negative results to 0 at the output
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a dot product; sampled only in IDLE
- `len`  in  5  number of terms, 0..16; values above 16 are treated as 16; sampled with `start`
- `filt_data`  in  DATA_W  `res` of the filter buffer at index `idx` (combinational)
- `in_data`  in  DATA_W  `res` of the input buffer at index `idx` (combinational)
- `idx`  out  IDX_W  read index, driven to the `i` port of both buffers
- `buf_lock`  out  1  high in RUN; upstream must not assert buffer `we` while high
- `busy`  out  1  high whenever the state is not IDLE
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  ACC_W  signed dot product, after optional ReLU

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE, on `start`:
  - `len`=0: clear the accumulator and go to OUT.
  - otherwise: latch `n = min(len,16)`, clear `idx`, the accumulator and `prod_v`, and go to RUN.
- RUN:
  - Each cycle, register `prod <= filt_data * in_data` (signed, 2·DATA_W bits) and set `prod_v <= 1`.
  - If `prod_v` was already set, also do `acc <= acc + sext(prod)`.
  - `idx` increments by 1 each cycle.
  - After the cycle where `idx == n-1`, go to DRAIN. `idx` holds at n-1 and does not wrap.
- DRAIN: `acc <= acc + sext(prod)` (the last product), clear `prod_v`, go to OUT.
- OUT:
  - `out_valid`=1.
  - `out_data` = acc, or 0 when `RELU`=1 and acc < 0.
  - Holds stable until `out_valid & out_ready`, then go to IDLE.
- `start` outside IDLE is ignored and not queued.
- Buffer writes are legal in every state except RUN. A write that lands during RUN is a protocol error; the resulting `out_data` is undefined.
- Asynchronous reset asserted mid-operation forces IDLE immediately; any partial sum is discarded.

## Timing
- Reset values: `idx`=0, `buf_lock`=0, `busy`=0, `out_valid`=0, `out_data`=0; accumulator, `prod` and `prod_v` all 0.
- Cycle numbering: the `start` edge ends cycle 0.
  - RUN occupies cycles 1..n, with `idx`=k−1 in cycle k.
  - DRAIN is cycle n+1.
  - `out_valid` rises in cycle n+2, so latency is n+2 cycles.
  - With `len`=0, `out_valid` rises in cycle 1 and `out_data`=0.
- Handshake:
  - `out_ready` may be high before `out_valid`; the transfer then completes in the first OUT cycle.
  - IDLE is entered the cycle after the transfer. The earliest next `start` is sampled in that IDLE cycle, so back-to-back jobs have a 1-cycle bubble.
- `busy` and `buf_lock` are registered state decodes and carry no combinational path from inputs.
- `out_data` is registered; it holds its last value in IDLE.

## Structure
- Package `mac_pkg`:
  - state enum (IDLE, RUN, DRAIN, OUT)
  - constants `MAC_DATA_W`=8, `MAC_IDX_W`=4, `MAC_DEPTH`=16, `MAC_ACC_W`=20
- Sub-module `mac_mul_stage`: registered signed multiplier with valid (`a`, `b`, `in_v` → `prod`, `prod_v`), async active-low reset.
- Top level: FSM, index counter, accumulator, ReLU mux, output register.

## Test plan
- All 16 entries = 1 in both buffers, `len`=16 → `out_data`=16; `out_valid` in cycle 18; `idx` sequence 0..15 observed in cycles 1..16.
- Filter all −128, input all −128, `len`=16 → `out_data`=262144 with no wrap. Filter all 127, input all −128 → −260096 with `RELU`=0, and 0 with `RELU`=1.
- Filter = {1,2,3,…}, input = {10,10,10,…}, `len`=3 → 60. `len`=0 → 0 with `out_valid` in cycle 1. `len`=20 → identical result to `len`=16.
- Hold `out_ready`=0 for 5 cycles in OUT while pulsing `start` → `out_data` stable, `start` ignored. Then `out_ready`=1 → one transfer, IDLE next cycle, new `start` accepted.
- Deassert `rst_n` in RUN at `idx`=7 → all outputs 0 immediately. After release, a fresh `len`=4 job returns the correct sum with no residue.
- Monitor checks that `buf_lock` is high exactly in cycles 1..n, and that `busy` falls the cycle after the output handshake.
